// File: rtl/usb_rx_phy_param.sv
// rtl/usb_rx_phy_param.sv - parametrised USB full-speed receive front end
// Recovers bits from raw D+/D- at CLKS_PER_BIT oversampling, NRZI-decodes and
// unstuffs them, checks SYNC/PID and queues payload bytes in a FWFT FIFO.
// Ports: clk, rst (sync, active-high); d_plus/d_minus raw line; rx_en enable;
//   byte_data/byte_last/byte_valid/byte_ready FIFO head handshake;
//   pid/pid_valid/pid_err PID result; rx_err framing-error pulse; rcving busy;
//   pckt_rcvd good-EOP pulse; overflow sticky drop flag; byte_count post-PID
//   byte count; crc_ok CRC16 residual match.
// Optional: define USB_RX_CRC16_EN to build the CRC16 checker; otherwise crc_ok is 0.
module usb_rx_phy_param #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_POINT = 4,
  parameter int FIFO_DEPTH   = 8,
  parameter int MAX_BYTES    = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           d_plus,
  input  logic                           d_minus,
  input  logic                           rx_en,
  output logic [7:0]                     byte_data,
  output logic                           byte_last,
  output logic                           byte_valid,
  input  logic                           byte_ready,
  output logic [3:0]                     pid,
  output logic                           pid_valid,
  output logic                           pid_err,
  output logic                           rx_err,
  output logic                           rcving,
  output logic                           pckt_rcvd,
  output logic                           overflow,
  output logic [$clog2(MAX_BYTES+1)-1:0] byte_count,
  output logic                           crc_ok
);

  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int PW  = AW + 1;
  localparam int BCW = $clog2(MAX_BYTES+1);

  typedef enum logic [2:0] {IDLE, SYNC, PID, DATA, EOP, ERR_WAIT} state_t;
  state_t state, state_n;

  // Input synchronizer; dp_q is one stage later for transition detection.
  logic dp_m, dp_s, dp_q, dm_m, dm_s;
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_m <= 1'b1; dp_s <= 1'b1; dp_q <= 1'b1; dm_m <= 1'b0; dm_s <= 1'b0;
    end else begin
      dp_m <= d_plus; dp_s <= dp_m; dp_q <= dp_s; dm_m <= d_minus; dm_s <= dm_m;
    end
  end

  // Bit counter re-aligns on every D+ transition.
  logic [CW-1:0] bit_cnt;
  always_ff @(posedge clk) begin
    if (rst || (dp_s != dp_q)) bit_cnt <= '0;
    else if (bit_cnt == CW'(CLKS_PER_BIT-1)) bit_cnt <= '0;
    else bit_cnt <= bit_cnt + CW'(1);
  end

  logic samp, ln_j, ln_k, ln_se0, ln_se1, nrzi, prev_dp;
  assign samp   = rx_en && (bit_cnt == CW'(SAMPLE_POINT));
  assign ln_j   = dp_s & ~dm_s;
  assign ln_k   = ~dp_s & dm_s;
  assign ln_se0 = ~dp_s & ~dm_s;
  assign ln_se1 = dp_s & dm_s;
  assign nrzi   = (dp_s == prev_dp);

  logic [7:0] shreg, shv, hold, push_d;
  logic [2:0] nbits, ones;
  logic       hold_v, push_v, push_l, se0_seen;
  logic       sync_ok, pid_ok, pid_bad, err, good_eop, byte_done, data_bit, stuff;

  assign shv   = {nrzi, shreg[7:1]};
  assign stuff = (ones == 3'd6);

  always_comb begin
    state_n   = state;
    sync_ok   = 1'b0;
    pid_ok    = 1'b0;
    pid_bad   = 1'b0;
    err       = 1'b0;
    good_eop  = 1'b0;
    byte_done = 1'b0;
    data_bit  = 1'b0;
    if (!rx_en) begin
      state_n = IDLE;
    end else if (samp) begin
      case (state)
        IDLE: if (ln_k) state_n = SYNC;
        SYNC, PID, DATA: begin
          if (ln_se1) begin
            err = 1'b1; state_n = ERR_WAIT;
          end else if (ln_se0) begin
            if (state == DATA) state_n = EOP;
            else begin err = 1'b1; state_n = ERR_WAIT; end
          end else if (stuff && nrzi) begin
            err = 1'b1; state_n = ERR_WAIT;
          end else if (!stuff) begin
            data_bit = 1'b1;
            if (nbits == 3'd7) begin
              if (state == SYNC) begin
                if (shv == 8'h80) begin sync_ok = 1'b1; state_n = PID; end
                else begin err = 1'b1; state_n = ERR_WAIT; end
              end else if (state == PID) begin
                if (shv[3:0] == ~shv[7:4]) begin pid_ok = 1'b1; state_n = DATA; end
                else begin pid_bad = 1'b1; state_n = ERR_WAIT; end
              end else if (byte_count == BCW'(MAX_BYTES)) begin
                err = 1'b1; state_n = ERR_WAIT;
              end else begin
                byte_done = 1'b1;
              end
            end
          end
        end
        EOP: begin
          if (ln_se1) begin
            err = 1'b1; state_n = ERR_WAIT;
          end else if (ln_j) begin
            state_n = IDLE;
            if (nbits == 3'd0) good_eop = 1'b1;
            else err = 1'b1;
          end
        end
        ERR_WAIT: if (se0_seen && ln_j) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // FIFO bookkeeping
  logic [8:0]  mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic empty, full, pop, wr_en;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = byte_valid & byte_ready;
  assign wr_en = push_v && (!full || pop);

  assign byte_valid = !empty;
  assign byte_data  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]][7:0];
  assign byte_last  = empty ? 1'b0  : mem[rd_ptr[AW-1:0]][8];
  assign rcving     = (state == SYNC) || (state == PID) || (state == DATA) || (state == EOP);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {push_l, push_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      prev_dp <= 1'b1; shreg <= '0; nbits <= '0; ones <= '0;
      hold <= '0; hold_v <= 1'b0; push_v <= 1'b0; push_d <= '0; push_l <= 1'b0;
      se0_seen <= 1'b0; pid <= '0; pid_valid <= 1'b0; pid_err <= 1'b0;
      rx_err <= 1'b0; pckt_rcvd <= 1'b0; byte_count <= '0; overflow <= 1'b0;
      wr_ptr <= '0; rd_ptr <= '0;
    end else begin
      state     <= state_n;
      pid_valid <= pid_ok;
      pid_err   <= pid_bad;
      rx_err    <= err;
      pckt_rcvd <= good_eop;
      // ERR_WAIT must see SE0 (possibly the one that caused the error) before J.
      se0_seen  <= (state_n == ERR_WAIT) && (se0_seen || (samp && ln_se0));
      if (samp) prev_dp <= dp_s;

      // The K that leaves IDLE is already the first (0) bit of SYNC.
      if (samp && state == IDLE && ln_k) begin
        shreg <= {1'b0, shreg[7:1]}; nbits <= 3'd1; ones <= 3'd0;
      end else if (data_bit) begin
        shreg <= shv; nbits <= nbits + 3'd1; ones <= nrzi ? ones + 3'd1 : 3'd0;
      end else if (samp && stuff && (ln_j || ln_k)) begin
        ones <= 3'd0;
      end

      if (pid_ok) begin
        pid <= shv[3:0]; byte_count <= '0;
      end else if (byte_done) begin
        byte_count <= byte_count + BCW'(1);
      end

      // One-byte holding stage so the final byte can be tagged last at EOP.
      push_v <= 1'b0;
      push_l <= 1'b0;
      if (byte_done) begin
        hold <= shv; hold_v <= 1'b1; push_v <= hold_v; push_d <= hold;
      end else if (good_eop) begin
        push_v <= hold_v; push_d <= hold; push_l <= 1'b1; hold_v <= 1'b0;
      end else if (pid_ok || state_n == IDLE || state_n == ERR_WAIT) begin
        hold_v <= 1'b0;
      end

      if (sync_ok) overflow <= 1'b0;
      else if (push_v && full && !pop) overflow <= 1'b1;

      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
    end
  end

`ifdef USB_RX_CRC16_EN
  // Serial CRC16 (0x8005) fed LSB-first, unrolled over the completed byte.
  logic [15:0] crc, crc_nx;
  always_comb begin
    crc_nx = crc;
    for (int i = 0; i < 8; i++) begin
      crc_nx = {crc_nx[14:0], 1'b0} ^ ((crc_nx[15] ^ shv[i]) ? 16'h8005 : 16'h0000);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc <= 16'hFFFF; crc_ok <= 1'b0;
    end else begin
      if (pid_ok) crc <= 16'hFFFF;
      else if (byte_done) crc <= crc_nx;
      if (sync_ok) crc_ok <= 1'b0;
      else if (good_eop) crc_ok <= (crc == 16'h800D);
    end
  end
`else
  assign crc_ok = 1'b0;
`endif

endmodule

// File: doc/usb_rx_phy_param.md
# usb_rx_phy_param

Parametrised USB full-speed receive front end. It recovers bits from the raw D+/D− pair at a configurable oversampling ratio, NRZI-decodes and unstuffs them, checks SYNC and PID, and assembles payload bytes into an output FIFO with a valid/ready handshake. It sits between the USB pads and the packet/protocol controller and is the successor of the fixed 8×-oversampled receiver. New over that receiver: a parametrised ratio and sample point, stuff-error and length checking, FIFO buffering with last-byte tagging, and optional CRC16 checking.

## Interface
- CLKS_PER_BIT, 8: clk cycles per USB bit; ≥4.
- SAMPLE_POINT, 4: bit-counter value at which the line is sampled; 1..CLKS_PER_BIT−2.
- FIFO_DEPTH, 8: byte FIFO entries; power of 2, ≥2.
- MAX_BYTES, 64: maximum bytes after the PID (payload + CRC).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- d_plus  in  1  raw D+, asynchronous
- d_minus  in  1  raw D−, asynchronous
- rx_en  in  1  receiver enable; low forces IDLE
- byte_data  out  8  FIFO head byte
- byte_last  out  1  head byte is the last byte of its packet
- byte_valid  out  1  FIFO non-empty
- byte_ready  in  1  consumer accepts the head byte
- pid  out  4  last accepted PID[3:0]
- pid_valid  out  1  1-cycle pulse when a PID is accepted
- pid_err  out  1  1-cycle pulse on PID check failure
- rx_err  out  1  1-cycle pulse on any framing error
- rcving  out  1  high from SYNC start until packet end or abort
- pckt_rcvd  out  1  1-cycle pulse on a good EOP
- overflow  out  1  sticky; a byte was dropped because the FIFO was full
- byte_count  out  $clog2(MAX_BYTES+1)  bytes received after the PID in the current or last packet
- crc_ok  out  1  CRC16 residual matched (see Configuration)

## Operation
- **Input conditioning.** d_plus/d_minus pass through a 2-flop synchronizer. Line states: J = (1,0), K = (0,1), SE0 = (0,0), SE1 = (1,1).
- **Bit counter.** Clears on every synchronized D+ transition and wraps at CLKS_PER_BIT−1. The line is sampled when the counter equals SAMPLE_POINT.
- **NRZI.** A sample equal to the previous sample decodes as 1; a changed sample decodes as 0.
- **Unstuffing.** After six consecutive 1s the next bit must be 0 and is discarded. A 1 in that position raises rx_err and moves to ERR_WAIT.
- **Bit order.** All fields are LSB-first.

FSM states:
- **IDLE:** rcving=0. A sampled K moves to SYNC.
- **SYNC:** collects 8 bits; the expected value is 0x80. On match: overflow clears and the FSM goes to PID. On mismatch: rx_err, then ERR_WAIT.
- **PID:** collects 8 bits.
  - If PID[3:0] == ~PID[7:4]: pid updates, pid_valid pulses, byte_count clears, state goes to DATA.
  - Otherwise: pid_err pulses, state goes to ERR_WAIT.
- **DATA:** every 8 bits form one byte.
  - Each completed byte goes into a 1-byte holding register.
  - The previously held byte is pushed to the FIFO with last=0.
  - byte_count increments; if it would exceed MAX_BYTES, rx_err and ERR_WAIT.
  - A sampled SE0 moves to EOP.
- **EOP:** waits for the first sampled J.
  - If 0 bits are pending: the held byte (if any) is pushed with last=1 and pckt_rcvd pulses.
  - If 1–7 bits are pending: they are discarded, rx_err pulses, no pckt_rcvd.
  - Next state is IDLE.
- **ERR_WAIT:** waits for SE0 followed by J, then goes to IDLE. No bytes are pushed.
- **SE1** sampled in any active state: rx_err, then ERR_WAIT.
- **rx_en low:** the FSM enters IDLE on the next cycle and the held byte is discarded. FIFO contents are kept.
- **FIFO push while full:** the byte is dropped and overflow sets. A push and a pop in the same cycle when full are both allowed.
- **rst:** all outputs 0, FIFO empty, FSM in IDLE.

## Timing
- Line edge to synchronized signal: 2 cycles.
- pid_valid, pid_err, rx_err and pckt_rcvd pulse in the cycle after the deciding sample.
- A byte is pushed in the cycle after the sample that completes the next byte. The packet's last byte is pushed in the cycle after the EOP J sample.
- The FIFO is first-word-fall-through: byte_data and byte_last are valid whenever byte_valid is high.
- A transfer occurs on byte_valid & byte_ready.
- byte_data and byte_last hold stable while byte_valid & !byte_ready.
- A pushed byte appears on byte_valid one cycle later.

## Configuration
- **USB_RX_CRC16_EN defined:**
  - A CRC16 register (polynomial 0x8005, init 0xFFFF) is clocked over every post-PID byte, including the two CRC bytes.
  - At a good EOP, crc_ok = (residual == 0x800D). It is valid from the pckt_rcvd cycle and holds until the next SYNC match.
- **Undefined:** no CRC logic is built and crc_ok is tied to 0.

## Test plan
- **ACK:** idle J, SYNC, PID 0xD2, SE0 ×2 bits, J → pid=4'h2 with one pid_valid pulse, one pckt_rcvd pulse, byte_valid stays 0, byte_count=0.
- **Zero-length DATA0:** PID 0xC3, then 0x00, 0x00 → two FIFO bytes 0x00/0x00 with byte_last=1 on the second, byte_count=2, crc_ok=1 (macro defined) or 0 (undefined).
- **Bit stuffing:**
  - Payload 0xFF, 0x00 with a correct stuff bit → bytes 0xFF, 0x00, no rx_err.
  - Same packet with the stuff bit replaced by 1 → rx_err pulse, no pckt_rcvd, FIFO empty.
- **Bad PID:** PID 0xC4 → pid_err pulse, pid_valid stays 0, no pckt_rcvd, next valid packet received normally.
- **Overflow:** FIFO_DEPTH=8, byte_ready=0, 10-byte payload → FIFO holds the first 8 bytes, overflow=1; after draining, the next SYNC clears overflow.
- **Aborts:**
  - rx_en driven low mid-DATA → rcving=0 on the next cycle, no pckt_rcvd.
  - rst asserted mid-packet → all outputs 0 the following cycle.
  - In both cases the next ACK packet decodes correctly.
